snitch_tcdm_bank_arbiter: RTL and testbench

SNITCH_TCDM_BANK_ARBITER -- requirements
Module: snitch_tcdm_bank_arbiter

---
 rtl/snitch_tcdm_bank_arbiter.sv | 101 ++++++++++
 tb/tb_snitch_tcdm_bank_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_tcdm_bank_arbiter.sv
// Round-robin arbiter putting NumReq requesters onto one single-cycle TCDM bank.
// Define SNITCH_TCDM_ARB_PERF_CNT_EN to add the conflict_cnt_o performance counter.
module snitch_tcdm_bank_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 64
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumReq-1:0]                    req_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]     add_i,
  input  logic [NumReq-1:0]                    wen_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]   be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
  output logic [NumReq-1:0]                    gnt_o,
  output logic [NumReq-1:0]                    rvalid_o,
  output logic [DataWidth-1:0]                 rdata_o,
  output logic                                 mem_cs_o,
  output logic                                 mem_wen_o,
  output logic [AddrWidth-1:0]                 mem_add_o,
  output logic [DataWidth/8-1:0]               mem_be_o,
  output logic [DataWidth-1:0]                 mem_wdata_o,
  input  logic [DataWidth-1:0]                 mem_rdata_i
`ifdef SNITCH_TCDM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]                          conflict_cnt_o
`endif
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [IdxW-1:0]             rr_q, rr_d, gnt_idx, rsp_idx_q;
  logic [NumReq-1:0][IdxW-1:0] cand;
  logic                        gnt_vld, rsp_vld_q;

  // cand[i] is the i-th index visited when searching upward from rr_q
  for (genvar i = 0; i < NumReq; i++) begin : g_cand
    assign cand[i] = IdxW'((32'(rr_q) + 32'(i)) % NumReq);
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (!gnt_vld && req_i[cand[i]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[i];
      end
    end
  end

  // Bank-side request is forced quiet while reset is held
  always_comb begin
    gnt_o       = '0;
    mem_cs_o    = 1'b0;
    mem_wen_o   = 1'b0;
    mem_add_o   = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (gnt_vld && rst_ni) begin
      gnt_o[gnt_idx] = 1'b1;
      mem_cs_o       = 1'b1;
      mem_wen_o      = wen_i[gnt_idx];
      mem_add_o      = add_i[gnt_idx];
      mem_be_o       = be_i[gnt_idx];
      mem_wdata_o    = wdata_i[gnt_idx];
    end
  end

  assign rr_d = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + IdxW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q      <= '0;
      rsp_vld_q <= 1'b0;
      rsp_idx_q <= '0;
    end else begin
      if (gnt_vld) rr_q <= rr_d;
      rsp_vld_q <= gnt_vld & ~wen_i[gnt_idx];
      if (gnt_vld) rsp_idx_q <= gnt_idx;
    end
  end

  for (genvar k = 0; k < NumReq; k++) begin : g_rvalid
    assign rvalid_o[k] = rsp_vld_q && (rsp_idx_q == IdxW'(k));
  end

  assign rdata_o = rsp_vld_q ? mem_rdata_i : '0;

`ifdef SNITCH_TCDM_ARB_PERF_CNT_EN
  logic multi_req;
  // Clearing the lowest set bit leaves something only if two or more bits were set
  assign multi_req = |(req_i & (req_i - NumReq'(1)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) conflict_cnt_o <= '0;
    else if (multi_req && (conflict_cnt_o != '1)) conflict_cnt_o <= conflict_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_snitch_tcdm_bank_arbiter.sv
// Scoreboard bench for snitch_tcdm_bank_arbiter: a reference model predicts grants,
// bank requests and read responses; a negedge monitor pops and compares them.
module tb_snitch_tcdm_bank_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int BW = DW / 8;

  logic                   clk = 1'b0;
  logic                   rst_ni = 1'b0;
  logic [N-1:0]           req_i = '0, wen_i = '0;
  logic [N-1:0][AW-1:0]   add_i = '0;
  logic [N-1:0][BW-1:0]   be_i = '0;
  logic [N-1:0][DW-1:0]   wdata_i = '0;
  logic [N-1:0]           gnt_o, rvalid_o;
  logic [DW-1:0]          rdata_o, mem_wdata_o;
  logic [DW-1:0]          mem_rdata_i = '0;
  logic                   mem_cs_o, mem_wen_o;
  logic [AW-1:0]          mem_add_o;
  logic [BW-1:0]          mem_be_o;
`ifdef SNITCH_TCDM_ARB_PERF_CNT_EN
  logic [31:0]            conflict_cnt_o;
`endif

  snitch_tcdm_bank_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
    .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .mem_cs_o(mem_cs_o), .mem_wen_o(mem_wen_o),
    .mem_add_o(mem_add_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
`ifdef SNITCH_TCDM_ARB_PERF_CNT_EN
    , .conflict_cnt_o(conflict_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int             due;
    int             conf;
    logic [N-1:0]   gnt;
    logic           cs, wen;
    logic [AW-1:0]  add;
    logic [BW-1:0]  be;
    logic [DW-1:0]  wdata;
  } gnt_t;
  typedef struct {
    int             due;
    logic [N-1:0]   rv;
    logic [DW-1:0]  data;
  } rsp_t;

  gnt_t gnt_q[$];
  rsp_t rsp_q[$];
  int   n_err = 0, n_chk = 0, cyc = 0;
  int   rr_m = 0, conf_m = 0;

  logic [DW-1:0] bank    [1 << AW];
  logic [DW-1:0] ref_mem [1 << AW];

  logic [N-1:0]         s_w;
  logic [N-1:0][AW-1:0] s_a;
  logic [N-1:0][BW-1:0] s_b;
  logic [N-1:0][DW-1:0] s_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-cycle bank driven by the DUT's bank-side port
  always @(posedge clk) begin
    if (mem_cs_o && mem_wen_o) begin
      for (int j = 0; j < BW; j++)
        if (mem_be_o[j]) bank[mem_add_o][8*j +: 8] <= mem_wdata_o[8*j +: 8];
      mem_rdata_i <= {$urandom, $urandom};
    end else if (mem_cs_o) begin
      mem_rdata_i <= bank[mem_add_o];
    end else begin
      mem_rdata_i <= {$urandom, $urandom};
    end
  end

  // Monitor
  gnt_t mg;
  rsp_t ms;
  always @(negedge clk) begin
    if (rst_ni) begin
      if (gnt_q.size() != 0) begin
        mg = gnt_q.pop_front();
        chk("gnt_cycle", 64'(cyc), 64'(mg.due));
        chk("gnt_o", 64'(gnt_o), 64'(mg.gnt));
        chk("mem_cs_o", 64'(mem_cs_o), 64'(mg.cs));
        chk("mem_wen_o", 64'(mem_wen_o), 64'(mg.wen));
        chk("mem_add_o", 64'(mem_add_o), 64'(mg.add));
        chk("mem_be_o", 64'(mem_be_o), 64'(mg.be));
        chk("mem_wdata_o", mem_wdata_o, mg.wdata);
`ifdef SNITCH_TCDM_ARB_PERF_CNT_EN
        chk("conflict_cnt_o", 64'(conflict_cnt_o), 64'(mg.conf));
`endif
      end
      if (rvalid_o != '0) begin
        if (rsp_q.size() == 0) chk("spurious_rvalid", 64'(rvalid_o), 64'(0));
        else begin
          ms = rsp_q.pop_front();
          chk("rvalid_cycle", 64'(cyc), 64'(ms.due));
          chk("rvalid_o", 64'(rvalid_o), 64'(ms.rv));
          chk("rdata_o", rdata_o, ms.data);
        end
      end else begin
        chk("rdata_idle", rdata_o, 64'(0));
        if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
          chk("missing_rvalid", 64'(rvalid_o), 64'(rsp_q[0].rv));
          void'(rsp_q.pop_front());
        end
      end
    end
  end

  // Drive one cycle (called just after a rising edge) and record what must happen
  task automatic step(input logic [N-1:0] r);
    gnt_t g;
    rsp_t s;
    int   k;
    req_i = r; wen_i = s_w; add_i = s_a; be_i = s_b; wdata_i = s_d;
    k = -1;
    for (int i = 0; i < N; i++)
      if (k < 0 && r[(rr_m + i) % N]) k = (rr_m + i) % N;
    g.due = cyc; g.conf = conf_m; g.gnt = '0; g.cs = 1'b0; g.wen = 1'b0;
    g.add = '0; g.be = '0; g.wdata = '0;
    if (k >= 0) begin
      g.gnt[k] = 1'b1; g.cs = 1'b1; g.wen = s_w[k];
      g.add = s_a[k]; g.be = s_b[k]; g.wdata = s_d[k];
      if (s_w[k]) begin
        for (int j = 0; j < BW; j++)
          if (s_b[k][j]) ref_mem[s_a[k]][8*j +: 8] = s_d[k][8*j +: 8];
      end else begin
        s.due = cyc + 1; s.rv = '0; s.rv[k] = 1'b1; s.data = ref_mem[s_a[k]];
        rsp_q.push_back(s);
      end
      rr_m = (k + 1) % N;
    end
    if ($countones(r) >= 2 && conf_m != 32'hFFFF_FFFF) conf_m++;
    gnt_q.push_back(g);
    @(posedge clk); #1;
  endtask

  task automatic rnd_fill();
    for (int i = 0; i < N; i++) begin
      s_w[i] = 1'($urandom_range(0, 1));
      s_a[i] = AW'($urandom_range(0, 15));
      s_b[i] = BW'($urandom);
      s_d[i] = {$urandom, $urandom};
    end
  endtask

  task automatic clr_fill();
    s_w = '0; s_a = '0; s_b = '0; s_d = '0;
  endtask

  task automatic idle(input int n);
    clr_fill();
    for (int i = 0; i < n; i++) step('0);
  endtask

  // Assert reset just after an edge, check every output is quiet, release after one edge
  task automatic do_reset();
    rst_ni = 1'b0;
    gnt_q.delete(); rsp_q.delete();
    rr_m = 0; conf_m = 0;
    rnd_fill();
    req_i = '1; wen_i = s_w; add_i = s_a; be_i = s_b; wdata_i = s_d;
    @(negedge clk);
    chk("rst_gnt_o", 64'(gnt_o), 64'(0));
    chk("rst_rvalid_o", 64'(rvalid_o), 64'(0));
    chk("rst_rdata_o", rdata_o, 64'(0));
    chk("rst_mem_cs_o", 64'(mem_cs_o), 64'(0));
    chk("rst_mem_wen_o", 64'(mem_wen_o), 64'(0));
    chk("rst_mem_add_o", 64'(mem_add_o), 64'(0));
    chk("rst_mem_be_o", 64'(mem_be_o), 64'(0));
    chk("rst_mem_wdata_o", mem_wdata_o, 64'(0));
`ifdef SNITCH_TCDM_ARB_PERF_CNT_EN
    chk("rst_conflict_cnt_o", 64'(conflict_cnt_o), 64'(0));
`endif
    @(posedge clk); #1;
    rst_ni = 1'b1;
    req_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      bank[i] = {$urandom, $urandom};
      ref_mem[i] = bank[i];
    end
    bank[5] = 64'hDEAD_BEEF;
    ref_mem[5] = 64'hDEAD_BEEF;

    do_reset();

    // Single read of address 5 by requester 0
    clr_fill(); s_a[0] = 10'h005;
    step(4'b0001);
    idle(2);

    // Full contention straight out of reset
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rnd_fill(); s_w = '0;
      step(4'b1111);
    end
    idle(2);

    // Write then read of the same word by requester 0
    clr_fill(); s_w[0] = 1'b1; s_a[0] = 10'h040; s_b[0] = 8'hFF; s_d[0] = 64'h1234;
    step(4'b0001);
    clr_fill(); s_a[0] = 10'h040;
    step(4'b0001);
    idle(2);

    // Pointer wrap: grant 2 moves rr to 3, then 0101 twice
    do_reset();
    clr_fill();
    step(4'b0100);
    step(4'b0101);
    step(4'b0101);
    idle(2);

    // Reset while a read to requester 2 is in flight
    clr_fill(); s_a[2] = 10'h007;
    step(4'b0100);
    do_reset();
    #3;
    chk("rvalid_after_rst", 64'(rvalid_o), 64'(0));
    rnd_fill(); s_w = '0;
    step(4'b1111);
    idle(2);

`ifdef SNITCH_TCDM_ARB_PERF_CNT_EN
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rnd_fill();
      step(i < 5 ? 4'b0011 : 4'b0001);
    end
    chk("conflict_cnt_5", 64'(conflict_cnt_o), 64'(5));
    idle(2);
`endif

    // Lone requester asserting every cycle
    for (int i = 0; i < 20; i++) begin
      rnd_fill();
      step(4'b0010);
    end

    // Random traffic on a small address window to exercise write/read hazards
    for (int i = 0; i < 400; i++) begin
      rnd_fill();
      step(($urandom_range(0, 9) == 0) ? 4'b0000 : N'($urandom));
    end
    idle(3);

    chk("gnt_q_drained", 64'(gnt_q.size()), 64'(0));
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
